move_scheduler: RTL and testbench

- Sequences one Othello move on the 8x8 board RAM (address = row*8+col, 0..63, 2-bit cells).
- Reads the board from the origin cell outward along all 8 directions to find capturing lines.
- For each capturing line it loads and launches the flipper, then waits for the flipper's done.
- Owns the board RAM port except while the flipper is running. Reports move validity and the number of discs flipped to the main controller.

---
 rtl/move_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_move_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: sequences one Othello move on the board RAM.
// Scans 8 directions from the origin and launches the flipper per captured line.
module move_scheduler #(
  parameter int BOARD_W = 8,
  parameter int ADDR_W  = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cell_addr,
  input  logic              player,
  output logic              busy,
  output logic              done,
  output logic              valid_move,
  output logic [5:0]        flip_count,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wren_o,
  output logic [1:0]        mem_data_o,
  input  logic [1:0]        mem_data_in,
  output logic              ctrl_mem_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [ADDR_W-1:0] step_o,
  output logic              ld_o,
  output logic              start_flip_o,
  input  logic              s_done_i
);

  localparam int RC_W = $clog2(BOARD_W);
  localparam logic [RC_W-1:0] RMAX = RC_W'(BOARD_W - 1);

  typedef enum logic [3:0] {
    IDLE, CHK_ORG, DIR_INIT, SCAN_ADDR, SCAN_WAIT, SCAN_READ,
    LAUNCH, FLIP_GO, FLIP_WAIT, NEXT_DIR, PLACE, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] org_q, org_d;
  logic [1:0]        own_q, own_d;
  logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
  logic [2:0]        dir_q, dir_d;
  logic [RC_W-1:0]   n_q, n_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic              any_q, any_d;
  logic              valid_q, valid_d;
  logic [5:0]        cnt_q, cnt_d;

  // direction vector as {row_inc, row_dec, col_inc, col_dec}
  function automatic logic [3:0] dir_of(input logic [2:0] d);
    unique case (d)
      3'd0: dir_of = 4'b0010;
      3'd1: dir_of = 4'b0001;
      3'd2: dir_of = 4'b1000;
      3'd3: dir_of = 4'b0100;
      3'd4: dir_of = 4'b1010;
      3'd5: dir_of = 4'b0101;
      3'd6: dir_of = 4'b1001;
      default: dir_of = 4'b0110;
    endcase
  endfunction

  function automatic logic off_edge(
    input logic [RC_W-1:0] r,
    input logic [RC_W-1:0] c,
    input logic [3:0]      dv
  );
    off_edge = (dv[3] && r == RMAX) || (dv[2] && r == '0) ||
               (dv[1] && c == RMAX) || (dv[0] && c == '0);
  endfunction

  function automatic logic [ADDR_W-1:0] step_of(input logic [3:0] dv);
    logic [ADDR_W-1:0] sr, sc;
    sr = dv[3] ? ADDR_W'(BOARD_W) : (dv[2] ? ADDR_W'(-BOARD_W) : '0);
    sc = dv[1] ? ADDR_W'(1) : (dv[0] ? '1 : '0);
    step_of = sr + sc;
  endfunction

  logic [3:0]        dv;
  logic [RC_W-1:0]   org_r, org_c, nr, nc;
  logic [ADDR_W-1:0] pos_addr, nxt_addr;
  logic [6:0]        sum;
  logic              is_opp, is_own;

  assign dv       = dir_of(dir_q);
  assign org_r    = org_q[2*RC_W-1:RC_W];
  assign org_c    = org_q[RC_W-1:0];
  assign nr       = dv[3] ? row_q + RC_W'(1) : (dv[2] ? row_q - RC_W'(1) : row_q);
  assign nc       = dv[1] ? col_q + RC_W'(1) : (dv[0] ? col_q - RC_W'(1) : col_q);
  assign pos_addr = ADDR_W'({row_q, col_q});
  assign nxt_addr = ADDR_W'({nr, nc});
  assign sum      = {1'b0, cnt_q} + 7'(n_q);
  assign is_own   = mem_data_in == own_q;
  assign is_opp   = mem_data_in == ~own_q;
  assign busy     = state_q != IDLE && state_q != FINISH;
  assign valid_move = valid_q;
  assign flip_count = cnt_q;

  always_comb begin
    state_d = state_q;
    org_d   = org_q;
    own_d   = own_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    any_d   = any_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    done         = 1'b0;
    mem_addr_o   = '0;
    mem_wren_o   = 1'b0;
    mem_data_o   = 2'b00;
    ctrl_mem_o   = 1'b1;
    s_addr_o     = '0;
    step_o       = '0;
    ld_o         = 1'b0;
    start_flip_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ctrl_mem_o = 1'b0;
        if (start) begin
          org_d   = cell_addr;
          own_d   = player ? 2'b10 : 2'b01;
          row_d   = cell_addr[2*RC_W-1:RC_W];
          col_d   = cell_addr[RC_W-1:0];
          cnt_d   = '0;
          any_d   = 1'b0;
          valid_d = 1'b0;
          wcnt_d  = '0;
          state_d = CHK_ORG;
        end
      end
      CHK_ORG: begin
        mem_addr_o = org_q;
        if (wcnt_q == 2'd2) begin
          if (mem_data_in == 2'b01 || mem_data_in == 2'b10) begin
            state_d = FINISH;
          end else begin
            dir_d   = '0;
            state_d = DIR_INIT;
          end
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      DIR_INIT: begin
        mem_addr_o = org_q;
        row_d = org_r;
        col_d = org_c;
        n_d   = '0;
        state_d = off_edge(org_r, org_c, dv) ? NEXT_DIR : SCAN_ADDR;
      end
      SCAN_ADDR: begin
        mem_addr_o = nxt_addr;
        row_d   = nr;
        col_d   = nc;
        state_d = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        mem_addr_o = pos_addr;
        state_d    = SCAN_READ;
      end
      SCAN_READ: begin
        mem_addr_o = pos_addr;
        if (is_opp) begin
          n_d = n_q + RC_W'(1);
          state_d = off_edge(row_q, col_q, dv) ? NEXT_DIR : SCAN_ADDR;
        end else if (is_own && n_q != '0) begin
          state_d = LAUNCH;
        end else begin
          state_d = NEXT_DIR;
        end
      end
      LAUNCH: begin
        ld_o     = 1'b1;
        s_addr_o = org_q;
        step_o   = step_of(dv);
        state_d  = FLIP_GO;
      end
      FLIP_GO: begin
        ctrl_mem_o   = 1'b0;
        start_flip_o = 1'b1;
        s_addr_o     = org_q;
        step_o       = step_of(dv);
        state_d      = FLIP_WAIT;
      end
      FLIP_WAIT: begin
        ctrl_mem_o = 1'b0;
        s_addr_o   = org_q;
        step_o     = step_of(dv);
        if (s_done_i) begin
          cnt_d   = sum[6] ? 6'h3f : sum[5:0];
          any_d   = 1'b1;
          state_d = NEXT_DIR;
        end
      end
      NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = PLACE;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = DIR_INIT;
        end
      end
      PLACE: begin
        mem_addr_o = org_q;
        mem_wren_o = any_q;
        mem_data_o = any_q ? own_q : 2'b00;
        valid_d    = any_q;
        state_d    = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      org_q   <= '0;
      own_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dir_q   <= '0;
      n_q     <= '0;
      wcnt_q  <= '0;
      any_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      org_q   <= org_d;
      own_q   <= own_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dir_q   <= dir_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      any_q   <= any_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: board RAM + flipper models, reference move model,
// scoreboard monitor checking launches, RAM writes and move results.
module tb_move_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] cell_addr = '0;
  logic       player = 1'b0;
  logic       busy, done, valid_move;
  logic [5:0] flip_count;
  logic [6:0] mem_addr_o, s_addr_o, step_o;
  logic       mem_wren_o, ctrl_mem_o, ld_o, start_flip_o;
  logic [1:0] mem_data_o;
  logic [1:0] rd1, rd2;
  logic       s_done;

  move_scheduler dut (
    .clock(clk), .reset(reset), .start(start),
    .cell_addr(cell_addr), .player(player),
    .busy(busy), .done(done), .valid_move(valid_move),
    .flip_count(flip_count), .mem_addr_o(mem_addr_o),
    .mem_wren_o(mem_wren_o), .mem_data_o(mem_data_o),
    .mem_data_in(rd2), .ctrl_mem_o(ctrl_mem_o),
    .s_addr_o(s_addr_o), .step_o(step_o), .ld_o(ld_o),
    .start_flip_o(start_flip_o), .s_done_i(s_done)
  );

  typedef struct packed {
    logic         valid;
    logic         quick;
    logic [5:0]   cnt;
    logic [6:0]   org;
    logic [1:0]   own;
    logic [127:0] brd;
  } exp_t;

  exp_t        res_q[$];
  logic [13:0] launch_q[$];
  int          checks = 0;
  int          failures = 0;
  int          moves_seen = 0;

  logic [1:0]   ram[64];
  logic [127:0] load_brd = '0;
  logic         load_req = 1'b0;
  logic         cur_pl = 1'b0;
  logic         f_active;
  int           f_wait;
  logic [6:0]   f_addr, f_step, f_cur;

  // board RAM with 2-cycle read latency, plus a behavioural flipper
  always @(posedge clk) begin
    logic [1:0] fown;
    fown = cur_pl ? 2'b10 : 2'b01;
    rd1 <= ram[mem_addr_o[5:0]];
    rd2 <= rd1;
    s_done <= 1'b0;
    if (load_req)
      for (int i = 0; i < 64; i++) ram[i] <= load_brd[2*i +: 2];
    if (ctrl_mem_o && mem_wren_o) ram[mem_addr_o[5:0]] <= mem_data_o;
    if (reset) begin
      f_active <= 1'b0;
      f_wait   <= 0;
    end else begin
      if (ld_o) begin
        f_addr <= s_addr_o;
        f_step <= step_o;
      end
      if (start_flip_o) begin
        f_active <= 1'b1;
        f_wait   <= int'($urandom_range(3, 6));
        f_cur    <= f_addr + f_step;
      end else if (f_active) begin
        if (f_wait > 0) begin
          f_wait <= f_wait - 1;
        end else if (ram[f_cur[5:0]] == ~fown) begin
          ram[f_cur[5:0]] <= fown;
          f_cur <= f_cur + f_step;
        end else begin
          s_done   <= 1'b1;
          f_active <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: walk each ray with plain row/col arithmetic
  task automatic issue(input logic [127:0] b, input int org, input bit pl);
    exp_t e;
    logic [1:0] own, opp;
    int dr[8], dc[8];
    int r, c, n;
    bit inb;
    dr = '{0, 0, 1, -1, 1, -1, 1, -1};
    dc = '{1, -1, 0, 0, 1, -1, -1, 1};
    own = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    e.org = 7'(org);
    e.own = own;
    e.valid = 1'b0;
    e.cnt = '0;
    e.brd = b;
    e.quick = (b[2*org +: 2] == 2'b01) || (b[2*org +: 2] == 2'b10);
    if (!e.quick) begin
      for (int d = 0; d < 8; d++) begin
        r = org / 8 + dr[d];
        c = org % 8 + dc[d];
        n = 0;
        inb = r >= 0 && r < 8 && c >= 0 && c < 8;
        while (inb && b[2*(r*8+c) +: 2] == opp) begin
          n++;
          r += dr[d];
          c += dc[d];
          inb = r >= 0 && r < 8 && c >= 0 && c < 8;
        end
        if (inb && n > 0 && b[2*(r*8+c) +: 2] == own) begin
          launch_q.push_back({7'(org), 7'(dr[d]*8 + dc[d])});
          for (int k = 1; k <= n; k++)
            e.brd[2*((org/8 + k*dr[d])*8 + org%8 + k*dc[d]) +: 2] = own;
          e.cnt = e.cnt + 6'(n);
          e.valid = 1'b1;
        end
      end
    end
    if (e.valid) e.brd[2*org +: 2] = own;
    res_q.push_back(e);
  endtask

  // monitor / scoreboard
  bit rst_chk = 1'b0;
  bit prev_busy = 1'b0;
  int lat = 0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [13:0] l;
    logic [127:0] cur;
    if (reset) begin
      res_q.delete();
      launch_q.delete();
      rst_chk = 1'b1;
      lat = 0;
      wait_cnt = 0;
    end else begin
      if (rst_chk) begin
        chk({busy, done, valid_move, flip_count, mem_addr_o, mem_wren_o,
             mem_data_o, ctrl_mem_o, s_addr_o, step_o, ld_o,
             start_flip_o} == '0, "reset_outputs", longint'(busy), 0);
        rst_chk = 1'b0;
      end
      lat++;
      if (start) lat = 0;
      if (f_active)
        chk(ctrl_mem_o == 1'b0, "ctrl_during_flip", longint'(ctrl_mem_o), 0);
      if (ld_o) begin
        if (launch_q.size() == 0) begin
          chk(1'b0, "unexpected_launch", longint'(step_o), -1);
        end else begin
          l = launch_q.pop_front();
          chk({s_addr_o, step_o} == l, "launch_step",
              longint'({s_addr_o, step_o}), longint'(l));
        end
      end
      if (mem_wren_o) begin
        if (res_q.size() == 0) begin
          chk(1'b0, "unexpected_write", longint'(mem_addr_o), -1);
        end else begin
          chk(res_q[0].valid && ctrl_mem_o && mem_addr_o == res_q[0].org
              && mem_data_o == res_q[0].own, "place_write",
              longint'({mem_addr_o, mem_data_o}),
              longint'({res_q[0].org, res_q[0].own}));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          e = res_q.pop_front();
          for (int i = 0; i < 64; i++) cur[2*i +: 2] = ram[i];
          chk(valid_move == e.valid, "valid_move",
              longint'(valid_move), longint'(e.valid));
          chk(flip_count == e.cnt, "flip_count",
              longint'(flip_count), longint'(e.cnt));
          checks++;
          if (cur != e.brd) begin
            failures++;
            $display("FAIL board: got %h expected %h", cur, e.brd);
          end
          chk(launch_q.size() == 0, "launches_left", launch_q.size(), 0);
          chk(prev_busy && !busy, "busy_at_done",
              longint'({prev_busy, busy}), 2);
          if (e.quick) chk(lat <= 6, "occupied_latency", lat, 6);
          launch_q.delete();
          wait_cnt = 0;
          moves_seen++;
        end
      end else if (res_q.size() > 0) begin
        wait_cnt++;
        if (wait_cnt > 5000) begin
          chk(1'b0, "done_timeout", wait_cnt, 5000);
          void'(res_q.pop_front());
          launch_q.delete();
          wait_cnt = 0;
          moves_seen++;
        end
      end
      prev_busy = busy;
    end
  end

  task automatic load(input logic [127:0] b, input bit pl);
    @(posedge clk); #1;
    load_brd = b;
    load_req = 1'b1;
    cur_pl = pl;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic do_move(input logic [127:0] b, input int org,
                         input bit pl, input bit poke);
    int target;
    load(b, pl);
    target = moves_seen + 1;
    issue(b, org, pl);
    cell_addr = 7'(org);
    player = pl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (5) @(posedge clk);
      #1;
      if (busy) begin
        cell_addr = 7'($urandom_range(0, 63));
        player = ~pl;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    for (int i = 0; i < 20000 && moves_seen < target; i++) @(posedge clk);
    if (moves_seen < target) begin
      $display("FAIL move_wait: got %0d expected %0d", moves_seen, target);
      $fatal(1, "stalled");
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b,
                                       input int i, input logic [1:0] v);
    logic [127:0] r;
    r = b;
    r[2*i +: 2] = v;
    return r;
  endfunction

  logic [127:0] opening, brd;
  initial begin
    opening = '0;
    opening = put(opening, 27, 2'b10);
    opening = put(opening, 28, 2'b01);
    opening = put(opening, 35, 2'b01);
    opening = put(opening, 36, 2'b10);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    do_move(opening, 19, 1'b0, 1'b0);
    do_move(opening, 27, 1'b0, 1'b0);
    do_move(put('0, 20, 2'b10), 19, 1'b0, 1'b0);
    brd = put(put('0, 8, 2'b10), 9, 2'b01);
    do_move(brd, 7, 1'b0, 1'b0);
    brd = put(put(put(put('0, 1, 2'b10), 2, 2'b01), 9, 2'b10), 18, 2'b01);
    do_move(brd, 0, 1'b0, 1'b0);

    // abandon a move while the flipper runs
    load(opening, 1'b0);
    issue(opening, 19, 1'b0);
    cell_addr = 7'd19;
    player = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && !start_flip_o; i++) @(negedge clk);
    if (!start_flip_o) begin
      $display("FAIL flip_start_wait: got 0 expected 1");
      $fatal(1, "stalled");
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    do_move(opening, 19, 1'b0, 1'b0);
    do_move(opening, 37, 1'b1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      int org, v;
      brd = '0;
      for (int i = 0; i < 64; i++) begin
        v = int'($urandom_range(0, 9));
        brd[2*i +: 2] = v < 3 ? 2'b00 : v < 6 ? 2'b01 : v < 9 ? 2'b10 : 2'b11;
      end
      org = int'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) brd[2*org +: 2] = 2'b00;
      do_move(brd, org, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
